rom_port: RTL and testbench

- Program-ROM and I/O-port peripheral on the CPU's 4-bit multiplexed bus, 4001-style.
- Tracks the CPU's 8-phase instruction cycle from `sync`.
- Captures the 12-bit fetch address, drives the two opcode nibbles back to the CPU, and implements the SRC-selected WRR/RDR 4-bit I/O port.
- Connects to the CPU's non-tristate `data`, `sync` and `rom_cmd` pins; fetches bytes from an external synchronous byte memory.

---
 rtl/rom_pkg.sv | 25 ++
 rtl/bus_phase_counter.sv | 38 +++
 rtl/rom_port.sv | 135 +++++++++++++
 tb/tb_rom_port.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared bus-cycle definitions for the 4-bit multiplexed CPU bus peripherals.
package rom_pkg;

  typedef logic [3:0] phase_t;

  localparam phase_t PH_IDLE = 4'd0;
  localparam phase_t PH_A1   = 4'd1;
  localparam phase_t PH_A2   = 4'd2;
  localparam phase_t PH_A3   = 4'd3;
  localparam phase_t PH_M1   = 4'd4;
  localparam phase_t PH_M2   = 4'd5;
  localparam phase_t PH_X1   = 4'd6;
  localparam phase_t PH_X2   = 4'd7;
  localparam phase_t PH_X3   = 4'd8;

  localparam logic [3:0] OPR_SRC = 4'h2;
  localparam logic [7:0] OP_WRR  = 8'hE2;
  localparam logic [7:0] OP_RDR  = 8'hEA;

  // SRC occupies the odd half of the 0x2 opcode row.
  function automatic logic is_src(input logic [7:0] inst);
    return (inst[7:4] == OPR_SRC) && inst[0];
  endfunction

endpackage

// File: rtl/bus_phase_counter.sv
// Eight-phase instruction-cycle tracker slaved to the CPU sync strobe.
module bus_phase_counter
  import rom_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   halt,
  input  logic   sync,
  output phase_t phase,
  output phase_t phase_nxt
);

  phase_t state_q;
  phase_t state_d;
  phase_t adv;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= PH_IDLE;
    else          state_q <= state_d;
  end

  // Sync restarts the cycle from any phase; X3 parks until the next sync.
  always_comb begin
    adv = PH_IDLE;
    if (sync)                    adv = PH_A1;
    else if (state_q == PH_IDLE) adv = PH_IDLE;
    else if (state_q == PH_X3)   adv = PH_X3;
    else if (state_q < PH_X3)    adv = state_q + 4'd1;
    else                         adv = PH_IDLE;
    state_d = halt ? state_q : adv;
  end

  always_comb begin
    phase     = state_q;
    phase_nxt = adv;
  end

endmodule

// File: rtl/rom_port.sv
// Program-ROM plus SRC-selected 4-bit I/O port on the multiplexed CPU bus.
module rom_port
  import rom_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       halt,
  input  logic       sync,
  input  logic       rom_cmd,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_en,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  phase_t ph;
  phase_t ph_nxt;

  logic [3:0] data_o_q,    data_o_d;
  logic       data_en_q,   data_en_d;
  logic [7:0] mem_addr_q,  mem_addr_d;
  logic       mem_rd_q,    mem_rd_d;
  logic [3:0] io_out_q,    io_out_d;
  logic [3:0] a3_q,        a3_d;
  logic       fetch_sel_q, fetch_sel_d;
  logic [7:0] opcode_q,    opcode_d;
  logic [7:0] inst_q,      inst_d;
  logic       src_sel_q,   src_sel_d;
  logic       drive_fetch;

  bus_phase_counter u_phase (
    .clock     (clock),
    .reset_n   (reset_n),
    .halt      (halt),
    .sync      (sync),
    .phase     (ph),
    .phase_nxt (ph_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_o_q    <= '0;
      data_en_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      io_out_q    <= '0;
      a3_q        <= '0;
      fetch_sel_q <= 1'b0;
      opcode_q    <= '0;
      inst_q      <= '0;
      src_sel_q   <= 1'b0;
    end else begin
      data_o_q    <= data_o_d;
      data_en_q   <= data_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      io_out_q    <= io_out_d;
      a3_q        <= a3_d;
      fetch_sel_q <= fetch_sel_d;
      opcode_q    <= opcode_d;
      inst_q      <= inst_d;
      src_sel_q   <= src_sel_d;
    end
  end

  always_comb begin
    data_o_d    = data_o_q;
    data_en_d   = data_en_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    io_out_d    = io_out_q;
    a3_d        = a3_q;
    fetch_sel_d = fetch_sel_q;
    opcode_d    = opcode_q;
    inst_d      = inst_q;
    src_sel_d   = src_sel_q;
    drive_fetch = 1'b0;

    if (!halt) begin
      mem_rd_d = (ph_nxt == PH_A3);

      // Latch bus content belonging to the phase that is ending on this edge.
      case (ph)
        PH_A1: mem_addr_d[3:0] = data_i;
        PH_A2: mem_addr_d[7:4] = data_i;
        PH_A3: begin
          a3_d        = data_i;
          fetch_sel_d = rom_cmd && (data_i == CHIP_ID);
          opcode_d    = mem_data;
        end
        PH_M1: inst_d[7:4] = fetch_sel_q ? opcode_q[7:4] : data_i;
        PH_M2: inst_d[3:0] = fetch_sel_q ? opcode_q[3:0] : data_i;
        PH_X2: begin
          if (is_src(inst_q) && rom_cmd) src_sel_d = (data_i == CHIP_ID);
          if ((inst_q == OP_WRR) && src_sel_q) io_out_d = data_i;
        end
        default: ;
      endcase

      // Bus drive is registered, so it is decided for the phase being entered.
      // The A3 nibble qualifies the fetch select so both records stay consistent.
      drive_fetch = fetch_sel_d && (a3_d == CHIP_ID);
      data_en_d   = 1'b0;
      data_o_d    = '0;
      case (ph_nxt)
        PH_M1: if (drive_fetch) begin
          data_en_d = 1'b1;
          data_o_d  = opcode_d[7:4];
        end
        PH_M2: if (drive_fetch) begin
          data_en_d = 1'b1;
          data_o_d  = opcode_d[3:0];
        end
        PH_X2: if ((inst_d == OP_RDR) && src_sel_d) begin
          data_en_d = 1'b1;
          data_o_d  = io_in;
        end
        default: ;
      endcase
    end
  end

  assign data_o   = data_o_q;
  assign data_en  = data_en_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q & ~halt;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_rom_port.sv
// Scoreboarded random and directed bench for rom_port with a per-instruction reference model.
module tb_rom_port;

  localparam logic [3:0] CHIP = 4'h3;

  typedef struct packed {
    logic       en;
    logic [3:0] o;
    logic       rd;
    logic [7:0] addr;
    logic [3:0] io;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       halt = 1'b0;
  logic       sync = 1'b0;
  logic       rom_cmd = 1'b0;
  logic [3:0] data_i = '0;
  logic [3:0] data_o;
  logic       data_en;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data = '0;
  logic [3:0] io_in = '0;
  logic [3:0] io_out;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Reference-model state visible at the instruction level.
  logic [7:0] m_addr = '0;
  logic [3:0] m_io = '0;
  logic       m_src = 1'b0;

  rom_port #(.CHIP_ID(CHIP)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .halt     (halt),
    .sync     (sync),
    .rom_cmd  (rom_cmd),
    .data_i   (data_i),
    .data_o   (data_o),
    .data_en  (data_en),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .io_in    (io_in),
    .io_out   (io_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("data_en", {7'd0, data_en}, {7'd0, e.en});
      chk("data_o", {4'd0, data_o}, {4'd0, e.o});
      chk("mem_rd", {7'd0, mem_rd}, {7'd0, e.rd});
      chk("mem_addr", mem_addr, e.addr);
      chk("io_out", {4'd0, io_out}, {4'd0, e.io});
    end
  end

  function automatic exp_t mk(input logic en, input logic [3:0] o, input logic rd);
    exp_t e;
    e.en = en; e.o = o; e.rd = rd; e.addr = m_addr; e.io = m_io;
    return e;
  endfunction

  task automatic step(input logic s, input logic h, input logic rc, input logic [3:0] d,
                      input logic rst_mid, input exp_t e);
    @(posedge clock);
    #1;
    if (!rst_mid) reset_n = 1'b1;
    sync = s; halt = h; rom_cmd = rc; data_i = d;
    if (rst_mid) begin
      #2 reset_n = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic run_cycle(input bit do_sync, input logic [7:0] addr, input logic [3:0] a3,
                           input logic rc_a3, input logic [7:0] mbyte, input logic [7:0] bus_inst,
                           input logic [3:0] x2, input logic rc_x2, input logic [3:0] iov,
                           input int halt_m1, input bit abort_m2, input bit reset_m1);
    logic       hit;
    logic       rdr;
    logic [7:0] ex;
    io_in = iov;
    if (do_sync) step(1'b1, 1'b0, 1'b0, 4'($urandom), 1'b0, mk(1'b0, 4'h0, 1'b0));
    step(1'b0, 1'b0, 1'b0, addr[3:0], 1'b0, mk(1'b0, 4'h0, 1'b0));
    m_addr[3:0] = addr[3:0];
    step(1'b0, 1'b0, 1'b0, addr[7:4], 1'b0, mk(1'b0, 4'h0, 1'b0));
    m_addr[7:4] = addr[7:4];
    mem_data = mbyte;
    step(1'b0, 1'b0, rc_a3, a3, 1'b0, mk(1'b0, 4'h0, 1'b1));
    hit = rc_a3 && (a3 == CHIP);
    ex  = hit ? mbyte : bus_inst;
    if (reset_m1) begin
      m_addr = '0; m_io = '0; m_src = 1'b0;
      step(1'b0, 1'b0, 1'b0, bus_inst[7:4], 1'b1, mk(1'b0, 4'h0, 1'b0));
      step(1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0, mk(1'b0, 4'h0, 1'b0));
      step(1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0, mk(1'b0, 4'h0, 1'b0));
      return;
    end
    for (int h = 0; h < halt_m1; h++)
      step((h == 0), 1'b1, 1'b0, 4'($urandom), 1'b0, mk(hit, hit ? mbyte[7:4] : 4'h0, 1'b0));
    step(1'b0, 1'b0, 1'b0, bus_inst[7:4], 1'b0, mk(hit, hit ? mbyte[7:4] : 4'h0, 1'b0));
    step(abort_m2, 1'b0, 1'b0, bus_inst[3:0], 1'b0, mk(hit, hit ? mbyte[3:0] : 4'h0, 1'b0));
    if (abort_m2) return;
    step(1'b0, 1'b0, 1'b0, 4'($urandom), 1'b0, mk(1'b0, 4'h0, 1'b0));
    rdr = (ex == 8'hEA) && m_src;
    step(1'b0, 1'b0, rc_x2, x2, 1'b0, mk(rdr, rdr ? iov : 4'h0, 1'b0));
    if ((ex == 8'hE2) && m_src) m_io = x2;
    if ((ex[7:4] == 4'h2) && ex[0] && rc_x2) m_src = (x2 == CHIP);
  endtask

  function automatic logic [7:0] pick_inst();
    logic [7:0] tbl [6];
    tbl[0] = 8'h21; tbl[1] = 8'h25; tbl[2] = 8'hE2;
    tbl[3] = 8'hEA; tbl[4] = 8'h20; tbl[5] = 8'($urandom);
    return tbl[$urandom_range(5)];
  endfunction

  initial begin
    // Reset held, then idle with bus noise and no sync.
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, mk(1'b0, 4'h0, 1'b0));
    step(1'b0, 1'b0, 1'b1, 4'hF, 1'b1, mk(1'b0, 4'h0, 1'b0));
    step(1'b0, 1'b0, 1'b1, 4'h7, 1'b0, mk(1'b0, 4'h0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 4'h9, 1'b0, mk(1'b0, 4'h0, 1'b0));

    run_cycle(1, 8'hA5, 4'h3, 1, 8'hD7, 8'h00, 4'h0, 0, 4'h0, 0, 0, 0);
    run_cycle(1, 8'hA5, 4'h2, 1, 8'hD7, 8'h21, 4'h3, 1, 4'h0, 0, 0, 0);
    run_cycle(1, 8'h3C, 4'h5, 0, 8'hFF, 8'hE2, 4'h9, 0, 4'h0, 0, 0, 0);
    run_cycle(1, 8'h11, 4'h3, 0, 8'h00, 8'hEA, 4'h0, 0, 4'hC, 0, 0, 0);
    run_cycle(1, 8'h12, 4'h0, 1, 8'h00, 8'h21, 4'h0, 1, 4'hC, 0, 0, 0);
    run_cycle(1, 8'h13, 4'h1, 0, 8'h00, 8'hEA, 4'h0, 0, 4'hC, 0, 0, 0);
    run_cycle(1, 8'h40, 4'h3, 1, 8'hD7, 8'h00, 4'h0, 0, 4'h0, 3, 0, 0);
    run_cycle(1, 8'h41, 4'h3, 1, 8'h6B, 8'h00, 4'h0, 0, 4'h0, 0, 1, 0);
    run_cycle(0, 8'h42, 4'h3, 1, 8'hEA, 8'h00, 4'h0, 0, 4'h5, 0, 0, 0);
    run_cycle(1, 8'h55, 4'h3, 1, 8'h9A, 8'h00, 4'h0, 0, 4'h0, 0, 0, 1);
    run_cycle(1, 8'h60, 4'h3, 1, 8'h21, 8'h00, 4'h3, 1, 4'h0, 0, 0, 0);
    run_cycle(1, 8'h61, 4'h3, 1, 8'hE2, 8'h00, 4'h6, 0, 4'h0, 0, 0, 0);
    run_cycle(1, 8'h62, 4'h3, 1, 8'hEA, 8'h00, 4'h1, 0, 4'hB, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic       rc_a3;
      logic [3:0] a3;
      logic [3:0] x2;
      rc_a3 = 1'($urandom);
      a3    = $urandom_range(1) ? CHIP : 4'($urandom);
      x2    = $urandom_range(1) ? CHIP : 4'($urandom);
      run_cycle(1, 8'($urandom), a3, rc_a3, pick_inst(), pick_inst(), x2,
                1'($urandom_range(3) != 0), 4'($urandom),
                ($urandom_range(7) == 0) ? 2 : 0, 0, 0);
    end

    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, mk(1'b0, 4'h0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, mk(1'b0, 4'h0, 1'b0));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    @(posedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
